// File: rtl/byte_stream_feeder.sv
// Serialises 32-bit stream words to one byte per cycle for the match/hash path,
// framing each batch with proc_start and a drain-delayed proc_last.
module byte_stream_feeder #(
  parameter int DRAIN_CYCLES = 70,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [31:0]      s_tdata,
  input  logic [3:0]       s_tkeep,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  output logic             s_tready,
  input  logic             proc_ready,
  output logic             proc_start,
  output logic [7:0]       proc_data,
  output logic             proc_data_valid,
  output logic             proc_last,
  output logic [CNT_W-1:0] byte_count,
  output logic             busy,
  output logic             keep_err
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, LAST} state_t;

  state_t          state, state_nxt;
  logic [31:0]     buf_data;
  logic            buf_valid, buf_last;
  logic [1:0]      idx;
  logic [2:0]      buf_n;
  logic [DW-1:0]   drain_cnt;
  logic [2:0]      keep_n, word_n;
  logic            keep_gap, at_end, emit, hs, fin, empty_last;

  // Only the contiguous run of enables from byte 0 counts; anything above a hole is dropped.
  always_comb begin
    keep_n   = 3'd0;
    keep_gap = 1'b0;
    casez (s_tkeep)
      4'b???0: begin keep_n = 3'd0; keep_gap = |s_tkeep[3:1]; end
      4'b??01: begin keep_n = 3'd1; keep_gap = |s_tkeep[3:2]; end
      4'b?011: begin keep_n = 3'd2; keep_gap = s_tkeep[3];    end
      default: begin keep_n = s_tkeep[3] ? 3'd4 : 3'd3;       end
    endcase
  end

  assign word_n     = s_tlast ? keep_n : 3'd4;
  assign at_end     = ({1'b0, idx} == (buf_n - 3'd1));
  assign s_tready   = (state == STREAM) && proc_ready && (!buf_valid || (at_end && !buf_last));
  assign hs         = s_tvalid && s_tready;
  assign emit       = (state == STREAM) && proc_ready && buf_valid;
  assign fin        = emit && at_end && buf_last;
  assign empty_last = hs && s_tlast && (word_n == 3'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = START;
      START:   state_nxt = STREAM;
      STREAM:  if (fin || empty_last) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == '0) state_nxt = LAST;
      LAST:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      buf_data        <= '0;
      buf_valid       <= 1'b0;
      buf_last        <= 1'b0;
      idx             <= '0;
      buf_n           <= '0;
      drain_cnt       <= '0;
      proc_start      <= 1'b0;
      proc_data       <= '0;
      proc_data_valid <= 1'b0;
      proc_last       <= 1'b0;
      byte_count      <= '0;
      busy            <= 1'b0;
      keep_err        <= 1'b0;
    end else begin
      proc_start      <= (state == IDLE) && (state_nxt == START);
      proc_last       <= (state_nxt == LAST);
      busy            <= (state_nxt != IDLE);
      proc_data_valid <= emit;

      if (emit) begin
        proc_data <= buf_data[{idx, 3'b000} +: 8];
        idx       <= idx + 2'd1;
        if (byte_count != {CNT_W{1'b1}}) byte_count <= byte_count + CNT_W'(1);
        if (at_end) buf_valid <= 1'b0;
      end

      // A load can coincide with emitting the previous word's final byte.
      if (hs) begin
        buf_data  <= s_tdata;
        buf_valid <= (word_n != 3'd0);
        buf_last  <= s_tlast;
        buf_n     <= word_n;
        idx       <= '0;
        if (s_tlast && keep_gap) keep_err <= 1'b1;
      end

      if (state == START) begin
        buf_valid  <= 1'b0;
        byte_count <= '0;
        keep_err   <= 1'b0;
      end

      if (state == STREAM && state_nxt == DRAIN) drain_cnt <= DW'(DRAIN_CYCLES - 1);
      else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - DW'(1);
    end
  end

endmodule

// File: tb/tb_byte_stream_feeder.sv
// Directed bench for byte_stream_feeder: framing, throughput, stalls, tkeep corners, reset.
module tb_byte_stream_feeder;
  localparam int D  = 6;
  localparam int CW = 32;

  logic          clk = 1'b0, reset_n = 1'b0, run = 1'b0;
  logic [31:0]   s_tdata = '0;
  logic [3:0]    s_tkeep = '0;
  logic          s_tvalid = 1'b0, s_tlast = 1'b0, proc_ready = 1'b1;
  logic          s_tready, proc_start, proc_data_valid, proc_last, busy, keep_err;
  logic [7:0]    proc_data;
  logic [CW-1:0] byte_count;

  byte_stream_feeder #(.DRAIN_CYCLES(D), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .run(run),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .proc_ready(proc_ready),
    .proc_start(proc_start), .proc_data(proc_data), .proc_data_valid(proc_data_valid),
    .proc_last(proc_last), .byte_count(byte_count), .busy(busy), .keep_err(keep_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle; tests look only at entries past their own base marks.
  logic [7:0] byte_q[$];
  int         vcyc_q[$], last_q[$], hs_q[$];
  int         n_start = 0, viol = 0;
  logic       prev_pr = 1'b1;
  always @(negedge clk) begin
    if (proc_data_valid) begin byte_q.push_back(proc_data); vcyc_q.push_back(cyc); end
    if (proc_last) last_q.push_back(cyc);
    if (s_tvalid && s_tready) hs_q.push_back(cyc);
    if (proc_start) n_start <= n_start + 1;
    if ((!prev_pr && proc_data_valid) || (!proc_ready && s_tready)) viol <= viol + 1;
    prev_pr <= proc_ready;
  end

  int bb, lb, hb, sb, vb;
  logic [31:0] wd[$];
  logic [3:0]  wk[$];
  logic [7:0]  exp_q[$];

  task automatic mark();
    bb = byte_q.size(); lb = last_q.size(); hb = hs_q.size(); sb = n_start; vb = viol;
  endtask

  task automatic pulse_run();
    @(posedge clk); #1 run = 1'b1;
    @(posedge clk); #1 run = 1'b0;
  endtask

  task automatic send_stream();
    int t;
    for (int i = 0; i < wd.size(); i++) begin
      @(posedge clk); #1;
      s_tvalid = 1'b1; s_tdata = wd[i]; s_tkeep = wk[i]; s_tlast = (i == wd.size() - 1);
      t = 0;
      @(negedge clk);
      while (!s_tready && t < 300) begin @(negedge clk); t++; end
      if (!s_tready) begin
        total++; bad++;
        $display("FAIL stream_timeout word=%0d tready=%b want 1", i, s_tready);
      end
    end
    @(posedge clk); #1 s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic wait_last(input int bound);
    int t = 0;
    while (last_q.size() == lb && t < bound) begin @(negedge clk); t++; end
    total++;
    if (last_q.size() == lb) begin bad++; $display("FAIL last_timeout got none want pulse"); end
  endtask

  task automatic wait_bytes(input int n);
    int t = 0;
    while (byte_q.size() < bb + n && t < 300) begin @(negedge clk); t++; end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    total++;
    if ({proc_start, proc_data_valid, proc_last, busy, keep_err, s_tready} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got %b want 000000",
                      {proc_start, proc_data_valid, proc_last, busy, keep_err, s_tready});
    end
    total++;
    if (proc_data !== 8'h00) begin bad++; $display("FAIL reset_data got %h want 00", proc_data); end
    total++;
    if (byte_count !== '0) begin bad++; $display("FAIL reset_count got %0d want 0", byte_count); end
  endtask

  task automatic test_basic();
    int n;
    mark();
    @(posedge clk); #1;
    s_tvalid = 1'b1; s_tdata = 32'h64636261; s_tkeep = 4'hf; s_tlast = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (s_tready !== 1'b0 || hs_q.size() != hb) begin
      bad++; $display("FAIL idle_tready got %b want 0", s_tready);
    end
    pulse_run();
    wd = '{32'h64636261, 32'h00006665}; wk = '{4'hf, 4'h3};
    exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
    send_stream();
    wait_last(200);
    repeat (2) @(negedge clk);
    n = byte_q.size() - bb;
    total++;
    if (n_start - sb != 1) begin bad++; $display("FAIL basic_starts got %0d want 1", n_start - sb); end
    total++;
    if (n != 6) begin bad++; $display("FAIL basic_nbytes got %0d want 6", n); end
    else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (byte_q[bb+i] !== exp_q[i]) begin
          bad++; $display("FAIL basic_byte%0d got %h want %h", i, byte_q[bb+i], exp_q[i]);
        end
      end
      total++;
      if (vcyc_q[bb+5] - vcyc_q[bb] != 5) begin
        bad++; $display("FAIL basic_contig got span %0d want 5", vcyc_q[bb+5] - vcyc_q[bb]);
      end
      total++;
      if (last_q.size() > lb && last_q[lb] != vcyc_q[bb+5] + D) begin
        bad++; $display("FAIL basic_last_time got %0d want %0d", last_q[lb], vcyc_q[bb+5] + D);
      end
    end
    total++;
    if (byte_count !== 6) begin bad++; $display("FAIL basic_count got %0d want 6", byte_count); end
    total++;
    if (busy !== 1'b0 || keep_err !== 1'b0) begin
      bad++; $display("FAIL basic_idle busy=%b keep_err=%b want 0 0", busy, keep_err);
    end
  endtask

  task automatic test_throughput();
    int ok;
    mark();
    pulse_run();
    wd = {}; wk = {};
    for (int i = 0; i < 8; i++) begin wd.push_back(32'h03020100 + 32'h04040404 * i); wk.push_back(4'hf); end
    send_stream();
    wait_last(200);
    @(negedge clk);
    total++;
    if (byte_q.size() - bb != 32) begin
      bad++; $display("FAIL thru_nbytes got %0d want 32", byte_q.size() - bb);
    end else begin
      ok = 1;
      for (int i = 0; i < 32; i++) if (byte_q[bb+i] !== 8'(i)) ok = 0;
      total++;
      if (!ok) begin bad++; $display("FAIL thru_bytes got out-of-order data want 00..1f"); end
      total++;
      if (vcyc_q[bb+31] - vcyc_q[bb] != 31) begin
        bad++; $display("FAIL thru_contig got span %0d want 31", vcyc_q[bb+31] - vcyc_q[bb]);
      end
    end
    total++;
    if (hs_q.size() - hb != 8) begin
      bad++; $display("FAIL thru_hs got %0d want 8", hs_q.size() - hb);
    end else begin
      ok = 1;
      for (int i = 1; i < 8; i++) if (hs_q[hb+i] - hs_q[hb+i-1] != 4) ok = 0;
      total++;
      if (!ok) begin bad++; $display("FAIL thru_tready_period got irregular want every 4"); end
    end
    total++;
    if (byte_count !== 32) begin bad++; $display("FAIL thru_count got %0d want 32", byte_count); end
  endtask

  task automatic test_backpressure();
    int ok;
    mark();
    pulse_run();
    wd = '{32'h13121110, 32'h17161514, 32'h1b1a1918}; wk = '{4'hf, 4'hf, 4'hf};
    fork
      send_stream();
      begin
        wait_bytes(6);
        @(posedge clk); #1 proc_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 proc_ready = 1'b1;
      end
    join
    wait_last(200);
    @(negedge clk);
    total++;
    if (viol - vb != 0) begin bad++; $display("FAIL bp_stall_activity got %0d want 0", viol - vb); end
    total++;
    if (byte_q.size() - bb != 12) begin
      bad++; $display("FAIL bp_nbytes got %0d want 12", byte_q.size() - bb);
    end else begin
      ok = 1;
      for (int i = 0; i < 12; i++) if (byte_q[bb+i] !== 8'(8'h10 + i)) ok = 0;
      total++;
      if (!ok) begin bad++; $display("FAIL bp_bytes got out-of-order data want 10..1b"); end
      total++;
      if (vcyc_q[bb+11] - vcyc_q[bb] != 16) begin
        bad++; $display("FAIL bp_span got %0d want 16", vcyc_q[bb+11] - vcyc_q[bb]);
      end
    end
    total++;
    if (byte_count !== 12) begin bad++; $display("FAIL bp_count got %0d want 12", byte_count); end
  endtask

  task automatic test_empty_last();
    mark();
    pulse_run();
    wd = '{32'hdeadbeef}; wk = '{4'h0};
    send_stream();
    wait_last(200);
    @(negedge clk);
    total++;
    if (byte_q.size() != bb) begin bad++; $display("FAIL empty_nbytes got %0d want 0", byte_q.size() - bb); end
    total++;
    if (byte_count !== 0) begin bad++; $display("FAIL empty_count got %0d want 0", byte_count); end
    total++;
    if (keep_err !== 1'b0) begin bad++; $display("FAIL empty_keep_err got %b want 0", keep_err); end
    total++;
    if (hs_q.size() <= hb || last_q.size() <= lb || last_q[lb] != hs_q[hb] + D + 1) begin
      bad++; $display("FAIL empty_last_time got %0d want %0d",
                      (last_q.size() > lb) ? last_q[lb] : -1, (hs_q.size() > hb) ? hs_q[hb] + D + 1 : -1);
    end
  endtask

  task automatic test_keep_gap();
    mark();
    pulse_run();
    wd = '{32'h44434241}; wk = '{4'b0101};
    send_stream();
    wait_last(200);
    @(negedge clk);
    total++;
    if (byte_q.size() - bb != 1) begin
      bad++; $display("FAIL gap_nbytes got %0d want 1", byte_q.size() - bb);
    end else begin
      total++;
      if (byte_q[bb] !== 8'h41) begin bad++; $display("FAIL gap_byte got %h want 41", byte_q[bb]); end
      total++;
      if (last_q.size() > lb && last_q[lb] != vcyc_q[bb] + D) begin
        bad++; $display("FAIL gap_last_time got %0d want %0d", last_q[lb], vcyc_q[bb] + D);
      end
    end
    total++;
    if (keep_err !== 1'b1) begin bad++; $display("FAIL gap_keep_err got %b want 1", keep_err); end
    total++;
    if (byte_count !== 1) begin bad++; $display("FAIL gap_count got %0d want 1", byte_count); end
  endtask

  task automatic test_ignored_run();
    mark();
    pulse_run();
    wd = '{32'h34333231, 32'h38373635}; wk = '{4'hf, 4'hf};
    fork
      send_stream();
      begin
        wait_bytes(1);
        pulse_run();
        wait_bytes(8);
        pulse_run();
      end
    join
    wait_last(200);
    repeat (10) @(negedge clk);
    total++;
    if (n_start - sb != 1) begin bad++; $display("FAIL ign_starts got %0d want 1", n_start - sb); end
    total++;
    if (last_q.size() - lb != 1) begin bad++; $display("FAIL ign_lasts got %0d want 1", last_q.size() - lb); end
    total++;
    if (byte_count !== 8) begin bad++; $display("FAIL ign_count got %0d want 8", byte_count); end
    total++;
    if (keep_err !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL ign_state keep_err=%b busy=%b want 0 0", keep_err, busy);
    end
  endtask

  task automatic test_reset_mid();
    mark();
    pulse_run();
    wd = '{32'h0d0c0b0a}; wk = '{4'hf};
    send_stream();
    wait_bytes(4);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    total++;
    if ({proc_start, proc_data_valid, proc_last, busy, keep_err, s_tready} !== 6'b0 ||
        proc_data !== 8'h00 || byte_count !== '0) begin
      bad++; $display("FAIL mid_reset_outputs flags=%b data=%h count=%0d want all 0",
                      {proc_start, proc_data_valid, proc_last, busy, keep_err, s_tready}, proc_data, byte_count);
    end
    repeat (3 * D) @(negedge clk);
    total++;
    if (last_q.size() != lb) begin bad++; $display("FAIL mid_no_last got %0d want 0", last_q.size() - lb); end
    mark();
    pulse_run();
    wd = '{32'h64636261, 32'h00006665}; wk = '{4'hf, 4'h3};
    send_stream();
    wait_last(200);
    @(negedge clk);
    total++;
    if (byte_q.size() - bb != 6 || byte_q[bb] !== 8'h61 || byte_q[bb+5] !== 8'h66) begin
      bad++; $display("FAIL mid_rerun_bytes got n=%0d want 6 bytes 61..66", byte_q.size() - bb);
    end
    total++;
    if (byte_count !== 6) begin bad++; $display("FAIL mid_rerun_count got %0d want 6", byte_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_throughput();
    test_backpressure();
    test_empty_last();
    test_keep_gap();
    test_ignored_run();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end
endmodule
